// File: rtl/output_port_arbiter_if.sv
// Switch-allocator handshake bundle for one router output port.
// Flit-type codes default here unless a shared parameters file defines them first.
`ifndef HEADER
`define HEADER 3'd1
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'd2
`endif
`ifndef TAIL
`define TAIL 3'd3
`endif

interface output_port_arbiter_if #(
  parameter int NUM_REQ = 5,
  parameter int CNT_W   = 3
);
  logic [NUM_REQ-1:0]   req;
  logic [3*NUM_REQ-1:0] flit_id;
  logic                 credit_in;
  logic [NUM_REQ-1:0]   grant;
  logic                 xfer;
  logic [CNT_W-1:0]     credits;
  logic                 busy;
  logic                 timeout_flag;

  modport master (
    output req, flit_id, credit_in,
    input  grant, xfer, credits, busy, timeout_flag
  );

  modport slave (
    input  req, flit_id, credit_in,
    output grant, xfer, credits, busy, timeout_flag
  );
endinterface

// File: rtl/output_port_arbiter.sv
// Wormhole round-robin output allocator with downstream credit tracking.
// Optional forced release of a stalled lock: define ARB_TIMEOUT_EN.
module output_port_arbiter #(
  parameter int NUM_REQ   = 5,
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 3,
  parameter int TIMEOUT   = 16
) (
  input logic                  clk,
  input logic                  rst,
  output_port_arbiter_if.slave arb
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cred_q, cred_d;
  logic               tflag_q, tflag_d;

  logic [2:0]         fid [NUM_REQ];
  logic [NUM_REQ-1:0] cand;
  logic               found;
  logic [IW-1:0]      pick, idx;
  logic               xfer, is_tail, tmo_hit;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign fid[i]  = arb.flit_id[3*i +: 3];
    assign cand[i] = arb.req[i] & (fid[i] == `HEADER);
  end

  // First header candidate at or after the round-robin pointer
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && cand[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign xfer = (state_q == LOCK) & arb.req[gidx_q]
              & (cred_q != '0) & ~rst;
  assign is_tail = (fid[gidx_q] == `TAIL);

  always_comb begin
    cred_d = cred_q;
    if (xfer && !arb.credit_in)
      cred_d = cred_q - CNT_W'(1);
    else if (!xfer && arb.credit_in
             && cred_q != CNT_W'(BUF_DEPTH))
      cred_d = cred_q + CNT_W'(1);
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_q, idle_d;

  always_comb begin
    idle_d  = '0;
    tmo_hit = 1'b0;
    if (state_q == LOCK && !xfer) begin
      if (idle_q == TW'(TIMEOUT - 1))
        tmo_hit = 1'b1;
      else
        idle_d = idle_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT == 0);
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    rr_ptr_d = rr_ptr_q;
    tflag_d  = tflag_q | tmo_hit;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (found) begin
          state_d = LOCK;
          gidx_d  = pick;
          grant_d = NUM_REQ'(1) << pick;
        end
      end
      (state_q == LOCK): begin
        if ((xfer && is_tail) || tmo_hit) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = (gidx_q == IW'(NUM_REQ - 1))
                   ? '0 : gidx_q + IW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
      cred_q   <= CNT_W'(BUF_DEPTH);
      tflag_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
      cred_q   <= cred_d;
      tflag_q  <= tflag_d;
    end
  end

  assign arb.grant        = grant_q;
  assign arb.xfer         = xfer;
  assign arb.credits      = cred_q;
  assign arb.busy         = (state_q == LOCK);
  assign arb.timeout_flag = tflag_q;
endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: vector table, directed corners, random vs model.
// Build with +define+ARB_TIMEOUT_EN to exercise the forced-release variant.
module tb_output_port_arbiter;
  localparam int N   = 5;
  localparam int BUF = 4;
  localparam int TMO = 16;
  localparam logic [2:0] FX = 3'd0;
  localparam logic [2:0] FH = 3'd1;
  localparam logic [2:0] FP = 3'd2;
  localparam logic [2:0] FT = 3'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  output_port_arbiter_if #(.NUM_REQ(N), .CNT_W(3)) bus ();

  output_port_arbiter #(
    .NUM_REQ(N), .BUF_DEPTH(BUF), .CNT_W(3), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arb(bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  bit m_lock;
  int m_own, m_ptr, m_cred, m_idle;
  bit m_tflag;

  typedef struct {
    logic [4:0]  req;
    logic [14:0] fid;
    logic        cin;
    logic [4:0]  g;
    logic        x;
    logic [2:0]  cr;
    logic        b;
  } vec_t;
  vec_t tbl [13];

  function automatic logic [14:0] at(int i, logic [2:0] t);
    logic [14:0] v;
    v = 15'(t) << (3 * i);
    return v;
  endfunction

  function automatic logic [2:0] mfid(int i);
    return bus.flit_id[3*i +: 3];
  endfunction

  function automatic bit m_xfer();
    return m_lock && bus.req[m_own] && m_cred != 0;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("grant", 32'(bus.grant), m_lock ? (32'd1 << m_own) : 32'd0);
    chk("xfer", 32'(bus.xfer), 32'(m_xfer()));
    chk("credits", 32'(bus.credits), 32'(m_cred));
    chk("busy", 32'(bus.busy), 32'(m_lock));
    chk("tflag", 32'(bus.timeout_flag), 32'(m_tflag));
  endtask

  task automatic m_release();
    m_lock = 1'b0;
    m_ptr  = (m_own + 1) % N;
    m_idle = 0;
  endtask

  // Reference behaviour for one clock edge, from current inputs
  task automatic m_update();
    bit x;
    bit got;
    int i;
    x = m_xfer();
    if (rst) begin
      m_lock = 0; m_own = 0; m_ptr = 0;
      m_cred = BUF; m_idle = 0; m_tflag = 0;
      return;
    end
    if (x && !bus.credit_in) m_cred--;
    else if (!x && bus.credit_in && m_cred < BUF) m_cred++;
    if (!m_lock) begin
      got = 0;
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (!got && bus.req[i] && mfid(i) == FH) begin
          got = 1; m_lock = 1; m_own = i; m_idle = 0;
        end
      end
    end else if (x && mfid(m_own) == FT) begin
      m_release();
    end
`ifdef ARB_TIMEOUT_EN
    else if (x) begin
      m_idle = 0;
    end else begin
      m_idle++;
      if (m_idle == TMO) begin
        m_release();
        m_tflag = 1;
      end
    end
`endif
  endtask

  task automatic step(output bit x, output int own);
    #1;
    chk_model();
    x   = m_xfer();
    own = m_own;
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("xfer_in_rst", 32'(bus.xfer), 32'd0);
    @(posedge clk);
    m_update();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(logic [4:0] r, logic [14:0] f, logic c);
    bus.req       = r;
    bus.flit_id   = f;
    bus.credit_in = c;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit x;
    int own, xc, pos;
    int pk [N];
    int order [$];
    logic [2:0] pkt [6];
    logic [14:0] f;
    logic [4:0] r;

    drive('0, '0, 1'b0);
    @(negedge clk);
    do_reset();

    tbl[0]  = '{5'b00010, at(1, FH), 0, 5'b00000, 0, 3'd4, 0};
    tbl[1]  = '{5'b00010, at(1, FH), 0, 5'b00010, 1, 3'd4, 1};
    tbl[2]  = '{5'b00010, at(1, FP), 0, 5'b00010, 1, 3'd3, 1};
    tbl[3]  = '{5'b00010, at(1, FP), 0, 5'b00010, 1, 3'd2, 1};
    tbl[4]  = '{5'b00010, at(1, FT), 0, 5'b00010, 1, 3'd1, 1};
    tbl[5]  = '{5'b00000, '0, 0, 5'b00000, 0, 3'd0, 0};
    tbl[6]  = '{5'b00000, '0, 1, 5'b00000, 0, 3'd0, 0};
    tbl[7]  = '{5'b00000, '0, 1, 5'b00000, 0, 3'd1, 0};
    tbl[8]  = '{5'b00000, '0, 1, 5'b00000, 0, 3'd2, 0};
    tbl[9]  = '{5'b00000, '0, 1, 5'b00000, 0, 3'd3, 0};
    tbl[10] = '{5'b00000, '0, 1, 5'b00000, 0, 3'd4, 0};
    tbl[11] = '{5'b00000, '0, 1, 5'b00000, 0, 3'd4, 0};
    tbl[12] = '{5'b00000, '0, 0, 5'b00000, 0, 3'd4, 0};

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].req, tbl[i].fid, tbl[i].cin);
      #1;
      chk("tbl_grant", 32'(bus.grant), 32'(tbl[i].g));
      chk("tbl_xfer", 32'(bus.xfer), 32'(tbl[i].x));
      chk("tbl_credits", 32'(bus.credits), 32'(tbl[i].cr));
      chk("tbl_busy", 32'(bus.busy), 32'(tbl[i].b));
      @(posedge clk);
      m_update();
      @(negedge clk);
    end

    // Contention: inputs 0,2,4 each send H,T
    drive('0, '0, 1'b0);
    do_reset();
    for (int i = 0; i < N; i++) pk[i] = (i % 2 == 0) ? 0 : 2;
    for (int c = 0; c < 30 && order.size() < 3; c++) begin
      r = '0; f = '0;
      for (int i = 0; i < N; i++)
        if (pk[i] < 2) begin
          r[i] = 1'b1;
          f |= at(i, pk[i] == 0 ? FH : FT);
        end
      drive(r, f, 1'b1);
      step(x, own);
      if (x) begin
        pk[own]++;
        if (pk[own] == 2) order.push_back(own);
      end
    end
    chk("order_len", 32'(order.size()), 32'd3);
    if (order.size() == 3) begin
      chk("order0", 32'(order[0]), 32'd0);
      chk("order1", 32'(order[1]), 32'd2);
      chk("order2", 32'(order[2]), 32'd4);
    end

    // Credit stall: 6-flit packet on input 1, no credits returned
    drive('0, '0, 1'b0);
    do_reset();
    pkt = '{FH, FP, FP, FP, FP, FT};
    pos = 0; xc = 0;
    for (int c = 0; c < 10; c++) begin
      drive(pos < 6 ? 5'b00010 : 5'b0,
            pos < 6 ? at(1, pkt[pos]) : 15'b0, 1'b0);
      step(x, own);
      if (x) begin pos++; xc++; end
    end
    chk("stall_xfers", 32'(xc), 32'd4);
    chk("stall_grant", 32'(bus.grant), 32'b00010);
    chk("stall_credits", 32'(bus.credits), 32'd0);
    xc = 0;
    for (int c = 0; c < 8; c++) begin
      drive(pos < 6 ? 5'b00010 : 5'b0,
            pos < 6 ? at(1, pkt[pos]) : 15'b0,
            c == 0 || c == 2);
      step(x, own);
      if (x) begin pos++; xc++; end
    end
    chk("resume_xfers", 32'(xc), 32'd2);
    chk("resume_busy", 32'(bus.busy), 32'd0);
    chk("resume_grant", 32'(bus.grant), 32'd0);

    // Simultaneous credit_in and xfer at credits=2
    drive('0, '0, 1'b0);
    do_reset();
    pkt = '{FH, FP, FP, FP, FT, FX};
    pos = 0;
    for (int c = 0; c < 7; c++) begin
      drive(pos < 5 ? 5'b00100 : 5'b0,
            pos < 5 ? at(2, pkt[pos]) : 15'b0, c == 3);
      step(x, own);
      if (x) pos++;
      if (c == 3) chk("cred_simul", 32'(bus.credits), 32'd2);
    end

    // Reset after two flits of a four-flit packet
    drive('0, '0, 1'b0);
    do_reset();
    pkt = '{FH, FP, FP, FT, FX, FX};
    pos = 0;
    for (int c = 0; c < 6 && pos < 2; c++) begin
      drive(5'b00010, at(1, pkt[pos]), 1'b0);
      step(x, own);
      if (x) pos++;
    end
    chk("mid_pos", 32'(pos), 32'd2);
    do_reset();
    chk("mid_grant", 32'(bus.grant), 32'd0);
    chk("mid_credits", 32'(bus.credits), 32'd4);
    for (int c = 0; c < 4; c++) begin
      drive(5'b00010, at(1, FP), 1'b0);
      step(x, own);
      chk("mid_nogrant", 32'(bus.grant), 32'd0);
    end

    // Stalled lock: header taken, then the input goes empty
    drive('0, '0, 1'b0);
    do_reset();
    drive(5'b01000, at(3, FH), 1'b0);
    step(x, own);
    for (int c = 0; c < TMO - 1; c++) begin
      drive('0, '0, 1'b0);
      step(x, own);
    end
    chk("tmo_pre_busy", 32'(bus.busy), 32'd1);
    step(x, own);
`ifdef ARB_TIMEOUT_EN
    chk("tmo_busy", 32'(bus.busy), 32'd0);
    chk("tmo_flag", 32'(bus.timeout_flag), 32'd1);
`else
    chk("tmo_busy", 32'(bus.busy), 32'd1);
    chk("tmo_flag", 32'(bus.timeout_flag), 32'd0);
`endif
    step(x, own);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(299) == 0) do_reset();
      r = 5'($urandom);
      f = '0;
      for (int i = 0; i < N; i++)
        f |= at(i, 3'($urandom_range(3)));
      drive(r, f, $urandom_range(2) == 0);
      step(x, own);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
